// File: rtl/rf_write_arbiter.sv
// Arbitrates two writeback requesters onto one register-file write port; result is registered (1 cycle).
// Never stalls: the loser of a contention keeps valid high and is retried; writes to r0 are accepted and dropped.
module rf_write_arbiter #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter bit FIXED_PRI = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD3,
    output logic              WE3,
    input  logic [ADDR_W-1:0] q_addr1,
    input  logic [ADDR_W-1:0] q_addr2,
    output logic              hazard1,
    output logic              hazard2,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic              last_grant;
    logic              grant_vld;
    logic              grant_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              contention;

    assign contention = req0_valid && req1_valid;

    // Grants are suppressed while reset is held so no handshake can complete.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        if (!rst) begin
            if (contention) begin
                grant_vld = 1'b1;
                grant_idx = FIXED_PRI ? 1'b0 : ~last_grant;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
                grant_idx = 1'b0;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_idx = 1'b1;
            end
        end
    end

    assign req0_ready = grant_vld && !grant_idx;
    assign req1_ready = grant_vld &&  grant_idx;
    assign sel_addr   = grant_idx ? req1_addr : req0_addr;
    assign sel_data   = grant_idx ? req1_data : req0_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A3           <= '0;
            WD3          <= '0;
            WE3          <= 1'b0;
            last_grant   <= 1'b1;
            conflict_cnt <= '0;
        end else begin
            if (grant_vld) begin
                A3         <= sel_addr;
                WD3        <= sel_data;
                WE3        <= (sel_addr != '0);
                last_grant <= grant_idx;
            end else begin
                WE3 <= 1'b0;
            end
            if (contention && (conflict_cnt != {CNT_W{1'b1}}))
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    // WE3 is already low for r0 writes; the A3 term keeps the hazard explicit.
    assign hazard1 = WE3 && (q_addr1 == A3) && (A3 != '0);
    assign hazard2 = WE3 && (q_addr2 == A3) && (A3 != '0);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench: round-robin/CNT_W=16 and fixed-priority/CNT_W=4 instances share one stimulus stream.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr, q_addr1, q_addr2;
    logic [31:0] req0_data, req1_data;

    logic        rr_req0_ready, rr_req1_ready, rr_WE3, rr_hazard1, rr_hazard2;
    logic [4:0]  rr_A3;
    logic [31:0] rr_WD3;
    logic [15:0] rr_cnt;
    logic        fp_req0_ready, fp_req1_ready, fp_WE3, fp_hazard1, fp_hazard2;
    logic [4:0]  fp_A3;
    logic [31:0] fp_WD3;
    logic [3:0]  fp_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.ADDR_W(5), .DATA_W(32), .FIXED_PRI(1'b0), .CNT_W(16)) u_rr (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(rr_req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(rr_req1_ready),
        .A3(rr_A3), .WD3(rr_WD3), .WE3(rr_WE3),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .hazard1(rr_hazard1), .hazard2(rr_hazard2),
        .conflict_cnt(rr_cnt)
    );

    rf_write_arbiter #(.ADDR_W(5), .DATA_W(32), .FIXED_PRI(1'b1), .CNT_W(4)) u_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(fp_req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(fp_req1_ready),
        .A3(fp_A3), .WD3(fp_WD3), .WE3(fp_WE3),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .hazard1(fp_hazard1), .hazard2(fp_hazard2),
        .conflict_cnt(fp_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_drive();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        next_drive();
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h1;
        req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h2;
        q_addr1 = 5'd0; q_addr2 = 5'd0;

        // Reset state, with both valids held
        #2;
        chk("rst_A3", rr_A3, 0);
        chk("rst_WD3", rr_WD3, 0);
        chk("rst_WE3", rr_WE3, 0);
        chk("rst_cnt", rr_cnt, 0);
        chk("rst_ready0", rr_req0_ready, 0);
        chk("rst_ready1", rr_req1_ready, 0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        next_drive();

        // Single req0 write
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("single_ready0", rr_req0_ready, 1);
        chk("single_ready1", rr_req1_ready, 0);
        next_drive();
        idle();
        @(negedge clk);
        chk("single_A3", rr_A3, 5);
        chk("single_WD3", rr_WD3, 32'hDEADBEEF);
        chk("single_WE3", rr_WE3, 1);
        @(negedge clk);
        chk("single_WE3_off", rr_WE3, 0);
        chk("single_A3_hold", rr_A3, 5);

        // Contention for 4 cycles after a fresh reset
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_ready0", rr_req0_ready, (i % 2 == 0));
            chk("rr_ready1", rr_req1_ready, (i % 2 == 1));
            chk("fp_ready0", fp_req0_ready, 1);
            chk("fp_ready1", fp_req1_ready, 0);
            if (i > 0) begin
                chk("rr_WE3_cont", rr_WE3, 1);
                chk("rr_A3_cont", rr_A3, ((i - 1) % 2 == 0) ? 32'd3 : 32'd4);
                chk("fp_A3_cont", fp_A3, 3);
            end
            next_drive();
        end
        idle();
        chk("rr_cnt4", rr_cnt, 4);
        chk("fp_cnt4", fp_cnt, 4);
        @(negedge clk);
        chk("rr_last_WE3", rr_WE3, 1);
        chk("rr_last_A3", rr_A3, 4);
        chk("rr_last_WD3", rr_WD3, 32'h22);
        chk("fp_last_WD3", fp_WD3, 32'h11);
        @(negedge clk);
        chk("rr_idle_WE3", rr_WE3, 0);
        chk("rr_idle_ready0", rr_req0_ready, 0);
        chk("rr_idle_cnt", rr_cnt, 4);

        // Write to r0 is accepted then dropped
        next_drive();
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFFFFFF;
        q_addr1 = 5'd0;
        @(negedge clk);
        chk("r0_ready1", rr_req1_ready, 1);
        next_drive();
        idle();
        @(negedge clk);
        chk("r0_WE3", rr_WE3, 0);
        chk("r0_WD3", rr_WD3, 32'hFFFFFFFF);
        chk("r0_hazard1", rr_hazard1, 0);

        // Hazard detection against in-flight write to r7
        next_drive();
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
        q_addr1 = 5'd7; q_addr2 = 5'd8;
        next_drive();
        idle();
        @(negedge clk);
        chk("haz_hazard1", rr_hazard1, 1);
        chk("haz_hazard2", rr_hazard2, 0);
        @(negedge clk);
        chk("haz_idle1", rr_hazard1, 0);
        chk("haz_idle2", rr_hazard2, 0);

        // Saturation over 19 contention cycles, then asynchronous reset mid-write
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h22;
        for (int i = 0; i < 19; i++) next_drive();
        chk("sat_fp_cnt", fp_cnt, 4'hF);
        chk("sat_rr_cnt", rr_cnt, 19);
        chk("pre_rst_WE3", rr_WE3, 1);
        rst = 1'b1;
        #1;
        chk("arst_WE3", rr_WE3, 0);
        chk("arst_A3", rr_A3, 0);
        chk("arst_WD3", rr_WD3, 0);
        chk("arst_cnt", rr_cnt, 0);
        chk("arst_fp_cnt", fp_cnt, 0);
        chk("arst_ready0", rr_req0_ready, 0);
        chk("arst_ready1", rr_req1_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready0", rr_req0_ready, 1);
        chk("post_rst_ready1", rr_req1_ready, 0);
        next_drive();
        idle();
        @(negedge clk);
        chk("post_rst_A3", rr_A3, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
